mdu_sequencer: RTL and testbench



---
 rtl/mdu_sequencer.sv | 152 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer for the execute stage.
// Owns HI/LO; 32-iteration shift-add multiply and restoring divide.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state_q, state_d;

    logic [4:0]         cnt_q;
    logic [1:0]         op_q;
    logic               sa_q, sb_q, dz_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, divzero_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     dsh;
    logic [WIDTH-1:0]   ddiff;
    logic               dge;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == 5'd0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand conditioning at issue: magnitudes plus sign bits
    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        abs_a = a_neg ? (~a + 1'b1) : a;
        abs_b = b_neg ? (~b + 1'b1) : b;
    end

    always_comb begin
        msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
        mul_nxt = {1'b0, acc_q[2*WIDTH-1:1]};
        if (acc_q[0]) mul_nxt = {msum, acc_q[WIDTH-1:1]};
    end

    // Shifted remainder needs WIDTH+1 bits before the compare
    always_comb begin
        dsh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        dge     = dsh >= {1'b0, opd_q};
        ddiff   = dsh[WIDTH-1:0] - opd_q;
        div_nxt = {dsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        if (dge) div_nxt = {ddiff, acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod   = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
        quot   = acc_q[WIDTH-1:0];
        rem    = acc_q[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (op_q[1]) begin
            fix_lo = (sa_q ^ sb_q) ? (~quot + 1'b1) : quot;
            fix_hi = sa_q ? (~rem + 1'b1) : rem;
            if (dz_q) fix_lo = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dz_q      <= 1'b0;
            opd_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            done_q    <= (state_q == FIX);
            divzero_q <= (state_q == FIX) && dz_q;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        sa_q  <= a_neg;
                        sb_q  <= b_neg;
                        dz_q  <= op[1] && (b == '0);
                        cnt_q <= 5'd31;
                        opd_q <= op[1] ? abs_b : abs_a;
                        acc_q <= op[1] ? {{WIDTH{1'b0}}, abs_a}
                                       : {{WIDTH{1'b0}}, abs_b};
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                RUN: begin
                    acc_q <= op_q[1] ? div_nxt : mul_nxt;
                    cnt_q <= cnt_q - 5'd1;
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign divzero = divzero_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: vector table, reference model,
// scoreboard of expected HI/LO, and interference sequences.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, divzero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done),
        .divzero(divzero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t   e;
        longint xa, yb, p, q, r;
        xa = o[0] ? longint'($signed(x)) : longint'({32'h0, x});
        yb = o[0] ? longint'($signed(y)) : longint'({32'h0, y});
        e.dz = 1'b0;
        if (!o[1]) begin
            p    = xa * yb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 32'h0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end else begin
            q    = xa / yb;
            r    = xa % yb;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input exp_t e,
                         input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy after issue", {63'b0, busy}, 64'd1);
    endtask

    task automatic finish_op(input string nm, input int exp_cyc);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        if (!done) begin
            chk({nm, " timeout"}, 64'(cyc), 64'(exp_cyc));
            if (sbq.size() != 0) void'(sbq.pop_front());
            return;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(exp_cyc));
        if (sbq.size() == 0) begin
            chk({nm, " scoreboard empty"}, 64'd0, 64'd1);
            return;
        end
        e = sbq.pop_front();
        chk({nm, " hi"}, {32'h0, hi}, {32'h0, e.hi});
        chk({nm, " lo"}, {32'h0, lo}, {32'h0, e.lo});
        chk({nm, " divzero"}, {63'b0, divzero}, {63'b0, e.dz});
        chk({nm, " busy at done"}, {63'b0, busy}, 64'd0);
        @(posedge clk);
        #1;
        chk({nm, " done width"}, {63'b0, done}, 64'd0);
        chk({nm, " idle after"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        exp_t        e;
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int          ndone;

        vecs[0] = '{"multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{"mult -3x7", 2'b01, 32'hFFFF_FFFD, 32'h7,
                    32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{"div -7/2", 2'b11, 32'hFFFF_FFF9, 32'h2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{"div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0, 32'h8000_0000, 1'b0};
        vecs[4] = '{"divu 7/0", 2'b10, 32'h7, 32'h0,
                    32'h7, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{"div -7/0", 2'b11, 32'hFFFF_FFF9, 32'h0,
                    32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{"divu 100/7", 2'b10, 32'd100, 32'd7,
                    32'd2, 32'd14, 1'b0};
        vecs[7] = '{"mult min*min", 2'b01, 32'h8000_0000, 32'h8000_0000,
                    32'h4000_0000, 32'h0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        mthi  = 1'b1;
        mtlo  = 1'b0;
        wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", {32'h0, hi}, 64'h0);
        chk("reset lo", {32'h0, lo}, 64'h0);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset divzero", {63'b0, divzero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mthi  = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e = '{vecs[i].hi, vecs[i].lo, vecs[i].dz};
            issue(vecs[i].op, vecs[i].a, vecs[i].b, e, 1'b1);
            finish_op(vecs[i].name, 33);
        end

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i == 5) ? 32'h0 : $urandom;
            issue(ro, rx, ry, model(ro, rx, ry), 1'b1);
            finish_op("random", 33);
        end

        // MULT then MTLO while idle
        issue(2'b01, 32'hFFFF_FFFD, 32'h7, model(2'b01, 32'hFFFF_FFFD, 32'h7), 1'b1);
        finish_op("mult again", 33);
        @(negedge clk);
        mtlo  = 1'b1;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        chk("mtlo lo", {32'h0, lo}, 64'h1234_5678);
        chk("mtlo hi kept", {32'h0, hi}, 64'hFFFF_FFFF);

        // start + mtlo mid-run are ignored
        issue(2'b00, 32'd5, 32'd6, '{32'h0, 32'd30, 1'b0}, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        mtlo  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        mtlo  = 1'b0;
        chk("mtlo busy dropped", {32'h0, lo}, 64'h1234_5678);
        finish_op("interference", 23);

        // reset mid-run
        issue(2'b00, 32'd5, 32'd6, '{32'h0, 32'd30, 1'b0}, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset busy", {63'b0, busy}, 64'd0);
        chk("midreset hi", {32'h0, hi}, 64'h0);
        chk("midreset lo", {32'h0, lo}, 64'h0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midreset no done", 64'(ndone), 64'd0);
        chk("scoreboard drained", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
